// File: rtl/rotary_pkg.sv
// rtl/rotary_pkg.sv - shared types and nibble helper for the rotary hex-entry editor
package rotary_pkg;

  typedef enum logic [1:0] {S_ADDR, S_DATA, S_WRITE} state_t;

  localparam int NIBBLE_W = 4;

  // dir = 1 steps up, dir = 0 steps down; wraps within the nibble, never carries
  function automatic logic [NIBBLE_W-1:0] nibble_step(input logic [NIBBLE_W-1:0] value,
                                                       input logic                dir);
    return dir ? value + 4'd1 : value - 4'd1;
  endfunction

endpackage

// File: rtl/nibble_field_reg.sv
// rtl/nibble_field_reg.sv - W-bit register with nibble-indexed inc/dec and whole-word increment
module nibble_field_reg
  import rotary_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  input  logic [1:0]   sel,
  input  logic         bump,
  output logic [W-1:0] value
);

  localparam int NIBBLES = W / NIBBLE_W;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (bump) begin
      value <= value + {{(W-1){1'b0}}, 1'b1};
    end else if (inc ^ dec) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (sel == 2'(i))
          value[i*NIBBLE_W +: NIBBLE_W] <= nibble_step(value[i*NIBBLE_W +: NIBBLE_W], inc);
      end
    end
  end

endmodule

// File: rtl/rotary_entry_controller.sv
// rtl/rotary_entry_controller.sv - rotary-encoder-driven address/data hex entry with req/ack write handoff
// Optional ADDR_AUTOINC_EN: after each write, bump the address and resume at the data MSB nibble.
module rotary_entry_controller
  import rotary_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              right,
  input  logic              left,
  input  logic              down,
  input  logic              wr_ack,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cursor_field,
  output logic [1:0]        cursor_digit,
  output logic              busy
);

  localparam logic [1:0] ADDR_MSB = 2'(ADDR_W / NIBBLE_W - 1);
  localparam logic [1:0] DATA_MSB = 2'(DATA_W / NIBBLE_W - 1);

  state_t state;

  // a press cancels any rotation in the same cycle; opposing rotations cancel each other
  logic rot_ok, edit_addr, edit_data, addr_bump;
  assign rot_ok    = (right ^ left) & ~down;
  assign edit_addr = rot_ok && (state == S_ADDR);
  assign edit_data = rot_ok && (state == S_DATA);

`ifdef ADDR_AUTOINC_EN
  assign addr_bump = (state == S_WRITE) && wr_ack;
`else
  assign addr_bump = 1'b0;
`endif

  nibble_field_reg #(.W(ADDR_W)) u_addr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (edit_addr & right),
    .dec   (edit_addr & left),
    .sel   (cursor_digit),
    .bump  (addr_bump),
    .value (wr_addr)
  );

  nibble_field_reg #(.W(DATA_W)) u_data (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (edit_data & right),
    .dec   (edit_data & left),
    .sel   (cursor_digit),
    .bump  (1'b0),
    .value (wr_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_ADDR;
      cursor_field <= 1'b0;
      cursor_digit <= ADDR_MSB;
      wr_req       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        S_ADDR: begin
          if (down) begin
            if (cursor_digit != 2'd0) begin
              cursor_digit <= cursor_digit - 2'd1;
            end else begin
              state        <= S_DATA;
              cursor_field <= 1'b1;
              cursor_digit <= DATA_MSB;
            end
          end
        end
        S_DATA: begin
          if (down) begin
            if (cursor_digit != 2'd0) begin
              cursor_digit <= cursor_digit - 2'd1;
            end else begin
              state  <= S_WRITE;
              wr_req <= 1'b1;
              busy   <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (wr_ack) begin
            wr_req <= 1'b0;
            busy   <= 1'b0;
`ifdef ADDR_AUTOINC_EN
            state        <= S_DATA;
            cursor_field <= 1'b1;
            cursor_digit <= DATA_MSB;
`else
            state        <= S_ADDR;
            cursor_field <= 1'b0;
            cursor_digit <= ADDR_MSB;
`endif
          end
        end
        default: begin
          state        <= S_ADDR;
          cursor_field <= 1'b0;
          cursor_digit <= ADDR_MSB;
          wr_req       <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rotary_entry_controller.sv
// tb/tb_rotary_entry_controller.sv - scoreboard bench with a nibble-array reference model
module tb_rotary_entry_controller;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int AN = AW / 4;
  localparam int DN = DW / 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic right = 1'b0, left = 1'b0, down = 1'b0, wr_ack = 1'b0;
  logic          wr_req, cursor_field, busy;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [1:0]    cursor_digit;

  rotary_entry_controller #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .right        (right),
    .left         (left),
    .down         (down),
    .wr_ack       (wr_ack),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .cursor_field (cursor_field),
    .cursor_digit (cursor_digit),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tag;
    int addr;
    int data;
    int field;
    int digit;
    int req;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model: phase 0 = address entry, 1 = data entry, 2 = waiting for ack
  int m_addr, m_data, m_phase, m_digit, m_req;

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic int edit_nibble(input int val, input int idx, input int up);
    int nib;
    nib = (val >> (4 * idx)) & 15;
    return val - (nib << (4 * idx)) + (((nib + (up ? 1 : 15)) % 16) << (4 * idx));
  endfunction

  task automatic model_reset();
    m_addr = 0; m_data = 0; m_phase = 0; m_digit = AN - 1; m_req = 0;
  endtask

  task automatic model_step(input int r, input int l, input int d, input int ack);
    if (m_phase == 2) begin
      if (ack != 0) begin
        m_req = 0;
`ifdef ADDR_AUTOINC_EN
        m_addr  = (m_addr + 1) % (1 << AW);
        m_phase = 1;
        m_digit = DN - 1;
`else
        m_phase = 0;
        m_digit = AN - 1;
`endif
      end
    end else if (d != 0) begin
      if (m_digit > 0) m_digit--;
      else if (m_phase == 0) begin m_phase = 1; m_digit = DN - 1; end
      else begin m_phase = 2; m_req = 1; end
    end else if (r != l) begin
      if (m_phase == 0) m_addr = edit_nibble(m_addr, m_digit, r);
      else m_data = edit_nibble(m_data, m_digit, r);
    end
  endtask

  // drive one cycle of inputs, predict, then wait until the result is visible
  task automatic step(input int r, input int l, input int d, input int ack);
    exp_t e;
    right = 1'(r); left = 1'(l); down = 1'(d); wr_ack = 1'(ack);
    model_step(r, l, d, ack);
    e.tag = cyc + 1; e.addr = m_addr; e.data = m_data;
    e.field = (m_phase != 0) ? 1 : 0; e.digit = m_digit; e.req = m_req;
    exp_q.push_back(e);
    @(negedge clk); #1;
  endtask

  task automatic rep(input int n, input int r, input int l, input int d);
    for (int i = 0; i < n; i++) step(r, l, d, 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: outputs are always presented, so each item is checked on its cycle
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("wr_addr", int'(wr_addr), e.addr);
      chk("wr_data", int'(wr_data), e.data);
      chk("cursor_field", int'(cursor_field), e.field);
      chk("cursor_digit", int'(cursor_digit), e.digit);
      chk("wr_req", int'(wr_req), e.req);
      chk("busy", int'(busy), e.req);
    end
  end

  task automatic async_reset();
    @(negedge clk); #1;
    right = 0; left = 0; down = 0; wr_ack = 0;
    rst_n = 1'b0;
    #1;
    chk("async wr_req", int'(wr_req), 0);
    chk("async wr_addr", int'(wr_addr), 0);
    chk("async wr_data", int'(wr_data), 0);
    chk("async busy", int'(busy), 0);
    model_reset();
    @(negedge clk); #1;
    rst_n = 1'b1;
    step(0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    chk("reset cursor_digit", int'(cursor_digit), AN - 1);
    chk("reset cursor_field", int'(cursor_field), 0);
    step(0, 0, 0, 0);

    rep(3, 1, 0, 0);
    chk("three rights", int'(wr_addr), 'h30);
    rep(4, 0, 1, 0);
    chk("four lefts", int'(wr_addr), 'hF0);

    rep(4, 1, 0, 0); step(0, 0, 1, 0);
    rep(10, 1, 0, 0); step(0, 0, 1, 0);
    rep(5, 1, 0, 0); step(0, 0, 1, 0);
    rep(4, 0, 1, 0); step(0, 0, 1, 0);
    chk("entry wr_req", int'(wr_req), 1);
    chk("entry wr_addr", int'(wr_addr), 'h3A);
    chk("entry wr_data", int'(wr_data), 'h5C);
    for (int i = 0; i < 5; i++) begin
      step(i % 2, (i + 1) % 2, i % 2, 0);
      chk("hold wr_req", int'(wr_req), 1);
      chk("hold wr_addr", int'(wr_addr), 'h3A);
      chk("hold wr_data", int'(wr_data), 'h5C);
    end
    step(0, 0, 0, 1);
    chk("ack wr_req", int'(wr_req), 0);
`ifdef ADDR_AUTOINC_EN
    chk("ack autoinc addr", int'(wr_addr), 'h3B);
    chk("ack cursor_field", int'(cursor_field), 1);
    chk("ack cursor_digit", int'(cursor_digit), DN - 1);
    step(1, 1, 0, 0);
    chk("right+left", int'(wr_data), 'h5C);
    step(1, 0, 1, 0);
    chk("down+right digit", int'(cursor_digit), 0);
    chk("down+right data", int'(wr_data), 'h5C);
`else
    chk("ack cursor_field", int'(cursor_field), 0);
    chk("ack cursor_digit", int'(cursor_digit), AN - 1);
    step(1, 1, 0, 0);
    chk("right+left", int'(wr_addr), 'h3A);
    step(1, 0, 1, 0);
    chk("down+right digit", int'(cursor_digit), 0);
    chk("down+right addr", int'(wr_addr), 'h3A);
    step(0, 0, 1, 0); step(0, 0, 1, 0);
`endif
    rep(3, 1, 0, 0);
    chk("lsb at F", int'(wr_data), 'h5F);
    step(1, 0, 0, 0);
    chk("lsb wrap", int'(wr_data), 'h50);

    step(0, 0, 1, 0);
    chk("pre-reset wr_req", int'(wr_req), 1);
    async_reset();

`ifdef ADDR_AUTOINC_EN
    step(0, 1, 0, 0); step(0, 0, 1, 0); step(0, 1, 0, 0); step(0, 0, 1, 0);
    rep(2, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("autoinc wrap addr", int'(wr_addr), 0);
    chk("autoinc field", int'(cursor_field), 1);
    chk("autoinc digit", int'(cursor_digit), DN - 1);
`endif

    for (int i = 0; i < 3000; i++) begin
      int r, l, d, a;
      r = ($urandom_range(0, 2) == 0) ? 1 : 0;
      l = ($urandom_range(0, 2) == 0) ? 1 : 0;
      d = ($urandom_range(0, 4) == 0) ? 1 : 0;
      a = ($urandom_range(0, 2) == 0) ? 1 : 0;
      step(r, l, d, a);
      if (i == 1500) async_reset();
    end

    @(negedge clk); #1;
    if (exp_q.size() != 0) chk("scoreboard drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
